dout_rr_arbiter: RTL and testbench
==================================

Name: dout_rr_arbiter

Overview:
- Shares a single dout stream (dout_valid/dout_data, no backpressure, as consumed by test_dout) between N packet requesters.
- Round-robin arbitration at packet granularity: grant locks on a source until its last beat.
- Output is registered.
- Sits between producer blocks and the dout sink; the dout sink is always ready.

Parameters:
- DWIDTH, 16, data width of each requester and of dout_data
- N, 4, number of requesters (1..16)
- SWIDTH, ($clog2(N) > 0 ? $clog2(N) : 1), width of source index
- TIMEOUT, 16, idle-owner cycles before forced release (used only with the optional feature)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-source beat valid
- req_data  input  N*DWIDTH  per-source data; source i occupies bits [i*DWIDTH +: DWIDTH]
- req_last  input  N  per-source last beat of packet, qualified by req_valid
- req_ready  output  N  per-source accept; one-hot or zero
- dout_valid  output  1  registered output beat valid
- dout_data  output  DWIDTH  registered output data
- dout_src  output  SWIDTH  index of the source of the current dout beat
- dout_last  output  1  registered last flag of the current beat
- timeout_err  output  1  one-cycle pulse on forced release; tied 0 without the feature

Behaviour:
- Reset values: all outputs 0; state IDLE; owner 0; rr pointer 0 (source 0 has highest priority first).
- States:
  - IDLE: if any req_valid, pick the first valid source searching from ptr upward (wrap at N); register owner; go to BUSY. req_ready is all-zero in IDLE.
  - BUSY: req_ready[owner]=1, other bits 0; req_ready is combinational from registered state only, never from req_valid.
- Transfer: a beat transfers when req_valid[owner] & req_ready[owner].
- Next cycle after a transfer: dout_valid=1, dout_data=captured data, dout_src=owner, dout_last=captured last.
  - Latency: 1 cycle from acceptance to dout.
- dout_valid=0 in any cycle following no transfer; dout_data, dout_src and dout_last hold their last values.
- Transfer with req_last=1: go to IDLE; ptr <= owner+1 mod N.
- Valid gaps in BUSY: grant is held and no dout beat is produced.
- Throughput: an L-beat packet occupies L+1 cycles (one arbitration bubble). A single-beat packet takes 2 cycles.
- Requests arriving while BUSY wait; there is no preemption.
- N=1: picker always selects 0; ptr stays 0.
- Async reset mid-packet: grant dropped, no dout_last emitted, ptr back to 0.
- Requesters hold valid/data/last stable until ready; the arbiter does not check this.

Optional Feature:
- Macro: DOUT_ARB_TIMEOUT_EN.
- With it:
  - A counter of consecutive BUSY cycles without req_valid[owner] runs; it is cleared on any owner valid and on entering BUSY.
  - On reaching TIMEOUT: go to IDLE, ptr <= owner+1, timeout_err pulses 1 for one cycle.
  - No dout beat or dout_last is generated for the abandoned packet.
- Without it: no counter; grant held indefinitely; timeout_err constant 0.

Decomposition:
- Package dout_arb_pkg:
  - state enum (ARB_IDLE, ARB_BUSY)
  - default width constants
  - function rr_first(valid vector, ptr) returning the index
- Sub-module dout_rr_pick: combinational round-robin picker; inputs valid[N] and ptr; outputs idx and any_valid.
- The top holds the FSM, capture registers and timeout counter.

Test Plan (DWIDTH=16, N=4, TIMEOUT=16):
- Source 2 only, 3-beat packet 0x0A01,0x0A02,0x0A03 (last on third):
  - dout shows the three beats on consecutive cycles, dout_src=2, dout_last only on 0x0A03.
  - req_ready[2] high 3 cycles.
- All 4 sources valid, single-beat packets 0x1000+i:
  - grant order 0,1,2,3; dout_valid pattern 1,0 repeating (bubble); ptr wraps, next 0.
- Source 1 in a 2-beat packet with a 3-cycle valid gap; source 3 requests mid-packet:
  - source 1 retains the grant, no dout beats during the gap.
  - source 3 is granted only after source 1's last beat.
- Reset asserted mid-packet of source 0:
  - all outputs 0 immediately.
  - after release with sources 0 and 2 valid, source 0 granted first.
- DOUT_ARB_TIMEOUT_EN defined; source 1 sends one non-last beat then drops valid:
  - after 16 idle BUSY cycles timeout_err pulses 1 cycle; no dout_last.
  - next grant goes to pending source 2.
- Macro undefined, same stimulus:
  - grant held, timeout_err stays 0.
  - source 1 resuming with a last beat completes normally.

Source files
------------

// File: rtl/dout_arb_pkg.sv
// Shared types and helpers for the round-robin dout arbiter.
// Holds the arbiter state encoding, default widths and the
// round-robin search function used by the picker.
package dout_arb_pkg;

    localparam int DEF_DWIDTH  = 16;
    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 16;

    // Upper bound on requester count; the search function is sized for it.
    localparam int MAX_N = 16;
    localparam int PTR_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // First set bit of valid[n-1:0] searching upward from ptr, wrapping at n.
    // Returns 0 when nothing is valid; callers qualify with an any-valid flag.
    function automatic logic [PTR_W-1:0] rr_first(
        input logic [MAX_N-1:0] valid,
        input logic [PTR_W-1:0] ptr,
        input int               n
    );
        logic [PTR_W-1:0] result;
        logic             found;
        int               s;
        result = '0;
        found  = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n && !found) begin
                s = int'(ptr) + k;
                if (s >= n) begin
                    s = s - n;
                end
                if (valid[s[PTR_W-1:0]]) begin
                    result = s[PTR_W-1:0];
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dout_rr_pick.sv
// Combinational round-robin picker.
// Selects the first valid requester at or above ptr, wrapping at N.
module dout_rr_pick
    import dout_arb_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int SWIDTH = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      valid,
    input  logic [SWIDTH-1:0] ptr,
    output logic [SWIDTH-1:0] idx,
    output logic              any_valid
);

    logic [MAX_N-1:0] valid_ext;
    logic [PTR_W-1:0] ptr_ext;
    logic [PTR_W-1:0] first;

    // Widen to the package search width, then narrow the winner back down.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid;
        ptr_ext            = PTR_W'(ptr);
        first              = rr_first(valid_ext, ptr_ext, N);
        idx                = SWIDTH'(first);
        any_valid          = |valid;
    end

endmodule

// File: rtl/dout_rr_arbiter.sv
// Round-robin arbiter sharing one registered dout stream between N
// packet requesters. A grant locks onto a source until its last beat;
// one idle cycle separates packets for arbitration.
// Optional build macro DOUT_ARB_TIMEOUT_EN: an owner that stays idle for
// TIMEOUT consecutive busy cycles is dropped and timeout_err pulses.
module dout_rr_arbiter
    import dout_arb_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int N       = DEF_N,
    parameter int SWIDTH  = ($clog2(N) > 0) ? $clog2(N) : 1,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid,
    input  logic [N*DWIDTH-1:0] req_data,
    input  logic [N-1:0]        req_last,
    output logic [N-1:0]        req_ready,
    output logic                dout_valid,
    output logic [DWIDTH-1:0]   dout_data,
    output logic [SWIDTH-1:0]   dout_src,
    output logic                dout_last,
    output logic                timeout_err
);

    // state    | meaning
    // ST_IDLE  | no owner; pick next source from ptr upward
    // ST_BUSY  | owner granted; beats flow until its last beat
    localparam logic [0:0] ST_IDLE = ARB_IDLE;
    localparam logic [0:0] ST_BUSY = ARB_BUSY;

    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("dout_rr_arbiter: N must be 1..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dout_rr_arbiter: TIMEOUT must be at least 1");
    end

    logic [0:0]        state;
    logic [SWIDTH-1:0] owner;
    logic [SWIDTH-1:0] ptr;
    logic [SWIDTH-1:0] owner_inc;
    logic [SWIDTH-1:0] pick_idx;
    logic              any_valid;
    logic [DWIDTH-1:0] src_data [N];
    logic [DWIDTH-1:0] owner_data;
    logic              owner_valid;
    logic              owner_last;
    logic              xfer;
    logic              force_rel;

    for (genvar g = 0; g < N; g++) begin : g_split
        assign src_data[g] = req_data[g*DWIDTH +: DWIDTH];
    end

    dout_rr_pick #(
        .N      (N),
        .SWIDTH (SWIDTH)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .idx       (pick_idx),
        .any_valid (any_valid)
    );

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign owner_data  = src_data[owner];
    assign xfer        = (state == ST_BUSY) && owner_valid;

    // Next pointer after the current owner, wrapping at N.
    always_comb begin
        if (owner == SWIDTH'(N - 1)) begin
            owner_inc = '0;
        end else begin
            owner_inc = owner + 1'b1;
        end
    end

    // Ready depends on registered state only, never on req_valid.
    always_comb begin
        req_ready = '0;
        if (state == ST_BUSY) begin
            req_ready[owner] = 1'b1;
        end
    end

    // Grant FSM: pick in idle, release on last beat or forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner <= pick_idx;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if ((xfer && owner_last) || force_rel) begin
                        state <= ST_IDLE;
                        ptr   <= owner_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: one beat per accepted transfer, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_src   <= '0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= xfer;
            if (xfer) begin
                dout_data <= owner_data;
                dout_src  <= owner;
                dout_last <= owner_last;
            end
        end
    end

`ifdef DOUT_ARB_TIMEOUT_EN
    localparam int CWIDTH = $clog2(TIMEOUT + 1);

    logic [CWIDTH-1:0] idle_cnt;

    // Release fires on the TIMEOUT-th consecutive busy cycle without owner valid.
    assign force_rel = (state == ST_BUSY) && !owner_valid &&
                       (idle_cnt == CWIDTH'(TIMEOUT - 1));

    // Idle-owner counter and the one-cycle error pulse on forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= force_rel;
            if (state != ST_BUSY || owner_valid || force_rel) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign force_rel   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dout_rr_arbiter.sv
// Scoreboard bench for dout_rr_arbiter (DWIDTH=16, N=4, TIMEOUT=16).
// Per-source packet queues feed a requester model that honours req_ready;
// expected dout beats are queued at issue and checked by a monitor.
module tb_dout_rr_arbiter;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int TO = 16;

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    req_valid;
    logic [NS*DW-1:0] req_data;
    logic [NS-1:0]    req_last;
    logic [NS-1:0]    req_ready;
    logic             dout_valid;
    logic [DW-1:0]    dout_data;
    logic [SW-1:0]    dout_src;
    logic             dout_last;
    logic             timeout_err;

    dout_rr_arbiter #(
        .DWIDTH  (DW),
        .N       (NS),
        .SWIDTH  (SW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .dout_valid  (dout_valid),
        .dout_data   (dout_data),
        .dout_src    (dout_src),
        .dout_last   (dout_last),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [7:0]    gap;
    } src_beat_t;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } exp_beat_t;

    src_beat_t src_q [NS][$];
    exp_beat_t sb [$];
    int        beat_cyc [$];
    int        ready_cnt [NS];
    int        to_cnt;
    int        to_cyc;
    int        cyc;
    int        total;
    int        bad;
    logic [NS-1:0] acc;

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester model: pop on acceptance, then present the next head beat.
    always @(posedge clk) begin
        src_beat_t b;
        acc = req_valid & req_ready;
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                if (b.gap > 0) begin
                    b.gap = b.gap - 8'd1;
                    src_q[i][0] = b;
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end else begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = b.last;
                    req_data[i*DW +: DW] = b.data;
                end
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Monitor: compare every dout beat against the scoreboard head.
    always @(negedge clk) begin
        exp_beat_t e;
        if (rst_n) begin
            for (int i = 0; i < NS; i++) ready_cnt[i] += int'(req_ready[i]);
            if (timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (dout_valid) begin
                beat_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dout_unexpected: got src=%0d data=0x%0h last=%0b with nothing expected",
                             dout_src, dout_data, dout_last);
                end else begin
                    e = sb.pop_front();
                    chk("dout_beat", 32'({dout_src, dout_data, dout_last}), 32'(e));
                end
            end
        end
    end

    task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l, input int gap);
        src_beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = 8'(gap);
        src_q[s].push_back(b);
    endtask

    task automatic expect_beat(input int s, input logic [DW-1:0] d, input logic l);
        exp_beat_t e;
        e.src  = SW'(s);
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic clear_src();
        for (int i = 0; i < NS; i++) src_q[i].delete();
    endtask

    task automatic start_test();
        @(posedge clk);
        #2;
        beat_cyc.delete();
        for (int i = 0; i < NS; i++) ready_cnt[i] = 0;
        to_cnt = 0;
        to_cyc = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < budget) begin
            @(negedge clk);
            #1;
            pend = sb.size();
            for (int i = 0; i < NS; i++) pend += src_q[i].size();
            n++;
        end
        chk(name, 32'(pend), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_src();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        to_cnt    = 0;
        to_cyc    = 0;
        for (int i = 0; i < NS; i++) ready_cnt[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_data", 32'(dout_data), 32'd0);
        chk("rst_dout_src", 32'(dout_src), 32'd0);
        chk("rst_dout_last", 32'(dout_last), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Source 2 alone, 3-beat packet
        start_test();
        push_beat(2, 16'h0A01, 1'b0, 0);
        push_beat(2, 16'h0A02, 1'b0, 0);
        push_beat(2, 16'h0A03, 1'b1, 0);
        expect_beat(2, 16'h0A01, 1'b0);
        expect_beat(2, 16'h0A02, 1'b0);
        expect_beat(2, 16'h0A03, 1'b1);
        wait_drain("t1_drain", 60);
        chk("t1_nbeats", 32'(beat_cyc.size()), 32'd3);
        chk("t1_gap01", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
        chk("t1_gap12", 32'(beat_cyc[2] - beat_cyc[1]), 32'd1);
        chk("t1_ready2_cycles", 32'(ready_cnt[2]), 32'd3);
        chk("t1_ready0_cycles", 32'(ready_cnt[0]), 32'd0);

        // All four sources, single-beat packets, from a fresh pointer
        do_reset();
        start_test();
        for (int i = 0; i < NS; i++) begin
            push_beat(i, 16'(16'h1000 + i), 1'b1, 0);
            expect_beat(i, 16'(16'h1000 + i), 1'b1);
        end
        wait_drain("t2_drain", 60);
        chk("t2_nbeats", 32'(beat_cyc.size()), 32'd4);
        for (int i = 1; i < NS; i++) chk("t2_bubble", 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd2);
        for (int i = 0; i < NS; i++) chk("t2_ready_cycles", 32'(ready_cnt[i]), 32'd1);

        // Pointer wrapped to 0: source 0 beats source 3
        start_test();
        push_beat(3, 16'h3333, 1'b1, 0);
        push_beat(0, 16'h0F0F, 1'b1, 0);
        expect_beat(0, 16'h0F0F, 1'b1);
        expect_beat(3, 16'h3333, 1'b1);
        wait_drain("t2_wrap_drain", 60);

        // Source 1 with a 3-cycle valid gap, source 3 arrives mid-packet
        start_test();
        push_beat(1, 16'hB101, 1'b0, 0);
        push_beat(1, 16'hB102, 1'b1, 3);
        push_beat(3, 16'hC301, 1'b1, 2);
        expect_beat(1, 16'hB101, 1'b0);
        expect_beat(1, 16'hB102, 1'b1);
        expect_beat(3, 16'hC301, 1'b1);
        wait_drain("t3_drain", 60);
        chk("t3_gap_no_beats", 32'(beat_cyc[1] - beat_cyc[0]), 32'd4);
        chk("t3_src3_after_last", 32'(beat_cyc[2] - beat_cyc[1]), 32'd2);
        chk("t3_ready1_held", 32'(ready_cnt[1]), 32'd5);
        chk("t3_ready3_cycles", 32'(ready_cnt[3]), 32'd1);

        // Move the pointer to 2, then reset in the middle of a source 0 packet
        start_test();
        push_beat(1, 16'hE1E1, 1'b1, 0);
        expect_beat(1, 16'hE1E1, 1'b1);
        wait_drain("t4_pre_drain", 40);
        start_test();
        push_beat(0, 16'hD001, 1'b0, 0);
        push_beat(0, 16'hD002, 1'b0, 0);
        push_beat(0, 16'hD003, 1'b1, 0);
        expect_beat(0, 16'hD001, 1'b0);
        begin
            int n;
            n = 0;
            while (beat_cyc.size() < 1 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("t4_first_beat_seen", 32'(beat_cyc.size()), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("t4_rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("t4_rst_dout_data", 32'(dout_data), 32'd0);
        chk("t4_rst_dout_src", 32'(dout_src), 32'd0);
        chk("t4_rst_dout_last", 32'(dout_last), 32'd0);
        chk("t4_rst_req_ready", 32'(req_ready), 32'd0);
        clear_src();
        repeat (2) @(negedge clk);
        push_beat(2, 16'h6002, 1'b1, 0);
        push_beat(0, 16'h6000, 1'b1, 0);
        expect_beat(0, 16'h6000, 1'b1);
        expect_beat(2, 16'h6002, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("t4_drain", 60);

        // Owner 1 stalls after a non-last beat; source 2 pending
        do_reset();
        start_test();
        push_beat(1, 16'hE101, 1'b0, 0);
        push_beat(1, 16'hE102, 1'b1, 20);
        push_beat(2, 16'hF201, 1'b1, 0);
        expect_beat(1, 16'hE101, 1'b0);
`ifdef DOUT_ARB_TIMEOUT_EN
        expect_beat(2, 16'hF201, 1'b1);
        expect_beat(1, 16'hE102, 1'b1);
        wait_drain("t5_drain", 100);
        chk("t5_timeout_pulses", 32'(to_cnt), 32'd1);
        chk("t5_timeout_delay", 32'(to_cyc - beat_cyc[0]), 32'd16);
        chk("t5_src2_after_timeout", 32'(beat_cyc[1] - to_cyc), 32'd2);
        chk("t5_src1_repacket", 32'(beat_cyc[2] - beat_cyc[0]), 32'd22);
`else
        expect_beat(1, 16'hE102, 1'b1);
        expect_beat(2, 16'hF201, 1'b1);
        wait_drain("t5_drain", 100);
        chk("t5_timeout_quiet", 32'(to_cnt), 32'd0);
        chk("t5_grant_held", 32'(beat_cyc[1] - beat_cyc[0]), 32'd21);
        chk("t5_src2_after_last", 32'(beat_cyc[2] - beat_cyc[1]), 32'd2);
        chk("t5_ready2_waits", 32'(ready_cnt[2]), 32'd1);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
